// File: rtl/serial_fsm_arbiter.sv
// Round-robin arbiter that time-shares one serial Mealy FSM among N requesters,
// streaming each granted burst through it and reporting the count of high FSM outputs.
module serial_fsm_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*LEN_W-1:0]   req_len,
    input  logic [N-1:0]         req_bit,
    output logic [N-1:0]         grant,
    output logic                 bit_ready,
    output logic                 fsm_clr,
    output logic                 fsm_in,
    input  logic                 fsm_out,
    output logic                 done,
    output logic [ID_W-1:0]      done_id,
    output logic [LEN_W-1:0]     hit_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t             state, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [LEN_W-1:0]   hit_q, hit_d;

    logic [N-1:0]       grant_d;
    logic               bit_ready_d;
    logic               fsm_clr_d;
    logic               done_d;
    logic [ID_W-1:0]    done_id_d;
    logic [LEN_W-1:0]   hit_count_d;

    logic [LEN_W-1:0]   len_arr [N];
    logic               arb_valid;
    logic [ID_W-1:0]    arb_sel;
    logic [ID_W-1:0]    arb_idx;

    for (genvar g = 0; g < N; g++) begin : g_len
        assign len_arr[g] = req_len[g*LEN_W +: LEN_W];
    end

    // Walk from farthest to nearest offset so the last hit is the first requester after ptr.
    always_comb begin
        arb_valid = 1'b0;
        arb_sel   = '0;
        arb_idx   = '0;
        for (int unsigned off = N; off >= 1; off--) begin
            arb_idx = ID_W'((32'(ptr_q) + off) % N);
            if (req[arb_idx]) begin
                arb_valid = 1'b1;
                arb_sel   = arb_idx;
            end
        end
    end

    assign fsm_in = (state == STREAM) ? req_bit[id_q] : 1'b0;

    // Next state plus next values of the registered outputs.
    always_comb begin
        state_d     = state;
        id_d        = id_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        hit_d       = hit_q;
        grant_d     = '0;
        bit_ready_d = 1'b0;
        fsm_clr_d   = 1'b0;
        done_d      = 1'b0;
        done_id_d   = done_id;
        hit_count_d = hit_count;

        unique case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_d   = CLEAR;
                    id_d      = arb_sel;
                    rem_d     = len_arr[arb_sel];
                    hit_d     = '0;
                    grant_d   = N'(1) << arb_sel;
                    fsm_clr_d = 1'b1;
                end
            end
            CLEAR: begin
                if (rem_q == '0) begin
                    state_d     = REPORT;
                    done_d      = 1'b1;
                    done_id_d   = id_q;
                    hit_count_d = '0;
                end else begin
                    state_d     = STREAM;
                    grant_d     = grant;
                    bit_ready_d = 1'b1;
                end
            end
            STREAM: begin
                hit_d = hit_q + LEN_W'(fsm_out);
                if (rem_q == LEN_W'(1)) begin
                    state_d     = REPORT;
                    done_d      = 1'b1;
                    done_id_d   = id_q;
                    hit_count_d = hit_d;
                end else begin
                    rem_d       = rem_q - LEN_W'(1);
                    grant_d     = grant;
                    bit_ready_d = 1'b1;
                end
            end
            REPORT: begin
                ptr_d   = id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            id_q      <= '0;
            ptr_q     <= ID_W'(N - 1);
            rem_q     <= '0;
            hit_q     <= '0;
            grant     <= '0;
            bit_ready <= 1'b0;
            fsm_clr   <= 1'b0;
            done      <= 1'b0;
            done_id   <= '0;
            hit_count <= '0;
        end else begin
            state     <= state_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            hit_q     <= hit_d;
            grant     <= grant_d;
            bit_ready <= bit_ready_d;
            fsm_clr   <= fsm_clr_d;
            done      <= done_d;
            done_id   <= done_id_d;
            hit_count <= hit_count_d;
        end
    end

endmodule

// File: tb/tb_serial_fsm_arbiter.sv
// Directed bench for serial_fsm_arbiter: stimulus pushes expected bursts,
// a negedge monitor pops them on done and checks protocol and results.
module tb_serial_fsm_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned ID_W  = 2;

    logic                 clk;
    logic                 reset;
    logic [N-1:0]         req;
    logic [N*LEN_W-1:0]   req_len;
    logic [N-1:0]         req_bit;
    logic [N-1:0]         grant;
    logic                 bit_ready;
    logic                 fsm_clr;
    logic                 fsm_in;
    logic                 fsm_out;
    logic                 done;
    logic [ID_W-1:0]      done_id;
    logic [LEN_W-1:0]     hit_count;

    serial_fsm_arbiter #(.N(N), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_len   (req_len),
        .req_bit   (req_bit),
        .grant     (grant),
        .bit_ready (bit_ready),
        .fsm_clr   (fsm_clr),
        .fsm_in    (fsm_in),
        .fsm_out   (fsm_out),
        .done      (done),
        .done_id   (done_id),
        .hit_count (hit_count)
    );

    // Shared FSM stand-in: a transparent Mealy machine.
    assign fsm_out = fsm_in;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [LEN_W-1:0] len;
        logic [LEN_W-1:0] hit;
    } exp_t;

    exp_t        exp_q [64];
    int          wr_idx;
    int          rd_idx;
    logic [15:0] pat [N];
    int          bursts_left [N];
    int          pos [N];
    int          timeouts;
    logic        fin;
    int          n_chk;
    int          n_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle of stimulus: advance granted requester's bit and drop satisfied requests.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fsm_clr && grant[i]) begin
                bursts_left[i] = bursts_left[i] - 1;
                pos[i] = 0;
            end
            if (bit_ready && grant[i]) begin
                req_bit[i] = pat[i][pos[i]];
                pos[i] = pos[i] + 1;
            end
            req[i] = (bursts_left[i] > 0);
        end
    endtask

    task automatic request(input int i, input logic [LEN_W-1:0] len,
                           input logic [15:0] p, input int nb);
        pat[i] = p;
        req_len[i*LEN_W +: LEN_W] = len;
        bursts_left[i] = nb;
        req[i] = 1'b1;
    endtask

    task automatic push(input int id, input int len, input int hit);
        exp_q[wr_idx] = {ID_W'(id), LEN_W'(len), LEN_W'(hit)};
        wr_idx = wr_idx + 1;
    endtask

    task automatic run_until_idle(input string name);
        int c;
        c = 0;
        while (c < 400 && !(rd_idx == wr_idx && req == '0 && grant == '0)) begin
            tick();
            c++;
        end
        if (c >= 400) begin
            $display("FAIL timeout %s: bursts still pending after %0d cycles", name, c);
            timeouts = timeouts + 1;
        end
        repeat (2) tick();
    endtask

    // Stimulus
    initial begin
        int c;
        reset    = 1'b0;
        req      = '0;
        req_len  = '0;
        req_bit  = '0;
        wr_idx   = 0;
        timeouts = 0;
        fin      = 1'b0;
        for (int i = 0; i < N; i++) begin
            pat[i] = '0;
            bursts_left[i] = 0;
            pos[i] = 0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) tick();

        // Abort a len=8 burst after three bits with reset.
        request(0, 4'd8, 16'hFFFF, 1);
        push(0, 8, 8);
        c = 0;
        while (c < 50 && pos[0] < 3) begin
            tick();
            c++;
        end
        if (c >= 50) begin
            $display("FAIL timeout reset_abort: stream never started");
            timeouts = timeouts + 1;
        end
        @(negedge clk);
        reset = 1'b0;
        bursts_left[0] = 0;
        req = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) tick();

        // req0 (1,0,1,1,0) and req1 (1,1,0) together: 0 first after reset.
        request(0, 4'd5, 16'b01101, 1);
        request(1, 4'd3, 16'b011, 1);
        push(0, 5, 3);
        push(1, 3, 2);
        run_until_idle("pair01");

        // Zero-length burst on req2.
        request(2, 4'd0, 16'hFFFF, 1);
        push(2, 0, 0);
        run_until_idle("len0");

        // req3 (1,1,0,1) leaves the pointer at 3.
        request(3, 4'd4, 16'b1011, 1);
        push(3, 4, 3);
        run_until_idle("req3");

        // All four held, len=2: order 0,1,2,3,0.
        request(0, 4'd2, 16'b11, 2);
        request(1, 4'd2, 16'b10, 1);
        request(2, 4'd2, 16'b00, 1);
        request(3, 4'd2, 16'b01, 1);
        push(0, 2, 2);
        push(1, 2, 1);
        push(2, 2, 0);
        push(3, 2, 1);
        push(0, 2, 2);
        run_until_idle("all4");

        // Maximum length, all ones: count reaches 15 without wrapping.
        request(1, 4'd15, 16'hFFFF, 1);
        push(1, 15, 15);
        run_until_idle("max");

        // Serve req3, then req3 and req0 together: 0 wins.
        request(3, 4'd1, 16'h0000, 1);
        push(3, 1, 0);
        run_until_idle("req3b");
        request(0, 4'd3, 16'b101, 1);
        request(3, 4'd2, 16'b11, 1);
        push(0, 3, 2);
        push(3, 2, 2);
        run_until_idle("pair30");

        fin = 1'b1;
        repeat (5) @(negedge clk);
        $display("FAIL end: monitor did not finish");
        $fatal(1, "monitor stalled");
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk = n_chk + 1;
        if (act !== want) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endfunction

    // Monitor / scoreboard
    initial begin
        int   neg;
        int   clr_neg;
        int   br_cnt;
        exp_t e;
        neg     = 0;
        clr_neg = 0;
        br_cnt  = 0;
        rd_idx  = 0;
        n_chk   = 0;
        n_err   = 0;
        forever begin
            @(negedge clk);
            neg++;
            if (!reset) begin
                rd_idx = wr_idx;
                chk("rst_grant", 32'(grant), 0);
                chk("rst_bit_ready", 32'(bit_ready), 0);
                chk("rst_fsm_clr", 32'(fsm_clr), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_done_id", 32'(done_id), 0);
                chk("rst_hit_count", 32'(hit_count), 0);
            end else begin
                chk("grant_onehot", 32'($countones(grant) <= 1), 1);
                if (fsm_clr) begin
                    chk("clr_expected", 32'(rd_idx != wr_idx), 1);
                    if (rd_idx != wr_idx)
                        chk("clr_grant", 32'(grant), 32'(N'(1) << exp_q[rd_idx].id));
                    chk("clr_no_bit_ready", 32'(bit_ready), 0);
                    chk("clr_fsm_in", 32'(fsm_in), 0);
                    clr_neg = neg;
                    br_cnt  = 0;
                end
                if (bit_ready && rd_idx != wr_idx) begin
                    e = exp_q[rd_idx];
                    chk("stream_grant", 32'(grant), 32'(N'(1) << e.id));
                    chk("fsm_in", 32'(fsm_in), 32'(pat[e.id][br_cnt]));
                    br_cnt++;
                end
                if (done) begin
                    chk("done_expected", 32'(rd_idx != wr_idx), 1);
                    if (rd_idx != wr_idx) begin
                        e = exp_q[rd_idx];
                        rd_idx = rd_idx + 1;
                        chk("done_id", 32'(done_id), 32'(e.id));
                        chk("hit_count", 32'(hit_count), 32'(e.hit));
                        chk("done_latency", 32'(neg - clr_neg), 32'(e.len) + 1);
                        chk("bit_ready_cycles", 32'(br_cnt), 32'(e.len));
                        chk("report_grant", 32'(grant), 0);
                    end
                end
            end
            if (fin) begin
                chk("timeouts", 32'(timeouts), 0);
                chk("pending_bursts", 32'(wr_idx - rd_idx), 0);
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
                $finish;
            end
        end
    end

endmodule

// File: doc/serial_fsm_arbiter.md
Name: serial_fsm_arbiter

Overview:
- Shares one single-bit Mealy sequence FSM among N requesters.
- Each requester asks to stream a burst of 0..2^LEN_W-1 serial bits through the shared FSM.
- The block grants requesters round-robin, clears the FSM before each burst, and drives that requester's bits into it one per cycle.
- It counts the cycles in which the FSM output is high and reports the count, tagged with the requester id, at burst end.

Parameters:
N, 4, number of requesters (2..8)
LEN_W, 4, width of burst-length field and of hit counter
ID_W, 2, width of requester id; must equal ceil(log2(N))

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  N  per-requester request level; sampled only in IDLE
req_len  in  N*LEN_W  flattened burst lengths; requester i uses bits [i*LEN_W +: LEN_W]
req_bit  in  N  per-requester serial data bit
grant  out  N  one-hot grant; held from CLEAR through STREAM
bit_ready  out  1  high in STREAM; granted requester advances req_bit after each clk edge where bit_ready=1
fsm_clr  out  1  synchronous clear pulse to shared FSM
fsm_in  out  1  serial bit to shared FSM (combinational mux of req_bit by latched id in STREAM, else 0)
fsm_out  in  1  Mealy output of shared FSM (combinational from fsm_in)
done  out  1  one-cycle pulse, burst complete
done_id  out  ID_W  id of completed requester; valid when done=1
hit_count  out  LEN_W  count of fsm_out=1 cycles in burst; valid when done=1

Behaviour:
- States: IDLE, CLEAR, STREAM, REPORT; state and all registered outputs are registers.
- Reset (reset=0, async): state=IDLE; grant=0; fsm_clr=0; bit_ready=0; done=0; done_id=0; hit_count=0; rr pointer=N-1, so requester 0 has top priority first.
- Reset mid-burst aborts the burst immediately. No done is issued.
- IDLE:
  - If req != 0, select the first set req bit searching upward from pointer+1, mod N.
  - Latch id and req_len[id]; clear remaining-count and hit counter; go to CLEAR.
  - Otherwise stay in IDLE.
- CLEAR (exactly 1 cycle): grant[id]=1; fsm_clr=1; fsm_in=0.
  - If latched len=0, go to REPORT; else go to STREAM.
- STREAM (exactly len cycles): grant[id]=1; bit_ready=1; fsm_in=req_bit[id].
  - Each cycle: hit counter += fsm_out; remaining -= 1.
  - When remaining reaches 1, go to REPORT after this cycle.
- REPORT (1 cycle):
  - done=1; done_id=id; hit_count=final count; grant=0.
  - Pointer<=id; go to IDLE.
- Timing: request seen at edge k; CLEAR occupies cycle k+1; done occurs at cycle k+2+len.
- Re-arbitration earliest at the edge ending REPORT's successor IDLE cycle. Minimum gap between bursts is 1 IDLE cycle.
- req changes outside IDLE are ignored. A burst always completes once granted. Requester deasserting req mid-burst has no effect.
- hit_count cannot overflow: count <= len <= 2^LEN_W-1.
- Simultaneous requests: strictly round-robin. A requester just served has lowest priority next arbitration.
- grant is never multi-hot; grant=0 in IDLE and REPORT.
- fsm_clr is high only in CLEAR.

Test Plan:
- Reset during STREAM (len=8, after 3 bits): reset low -> grant=0, done never pulses. After release, req0 served first.
- Single req0, len=5, req_bit stream 1,0,1,1,0, bench fsm_out=fsm_in -> fsm_clr 1 cycle; bit_ready 5 cycles; done at cycle k+7; done_id=0; hit_count=3.
- req0..3 all held high, len=2 each -> grants in order 0,1,2,3,0. Each done_id matches. Grant one-hot at all times.
- req2 len=0 -> CLEAR then REPORT; done at k+2; hit_count=0; bit_ready never asserted.
- req1 len=15, all bits 1, fsm_out=1 -> hit_count=15 (max, no wrap). req1 dropped after cycle 4 still yields done.
- After serving req3, req3 and req0 raised together -> req0 granted first, then req3.
